// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-LED linear brightness fader driving frame-synchronous PWM
// outputs. Static on/off levels from the SoC ramp up and down one brightness
// step per prescaler tick, and a shadowed duty register keeps every PWM frame
// glitch-free.
module led_fade_pwm #(
    parameter int N_LED    = 4,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LED-1:0]    led_i,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [N_LED-1:0]    led_o,
    output logic                busy
);

    localparam int                  PS_W     = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RISE,
        ST_ON,
        ST_FALL
    } state_t;

    // Reset synchroniser: asserts with rst, releases two clock edges later.
    logic [1:0] rst_pipe_q, rst_pipe_d;
    logic       rst_int;

    logic [N_LED-1:0]                led_q, led_d;
    logic [PS_W-1:0]                 presc_q, presc_d;
    logic                            tick;
    logic [PWM_BITS-1:0]             pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0][PWM_BITS-1:0]  bright_q, bright_d;
    logic [N_LED-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [N_LED-1:0]                led_o_q, led_o_d;
    logic                            busy_q, busy_d;
    state_t                          state_q [N_LED];
    state_t                          state_d [N_LED];

    assign rst_int = rst_pipe_q[1];

    // Reset release pipeline; the internal reset is the last stage.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops are written with <= so each one samples pre-edge values,
        // independent of statement order.
        if (rst) begin
            rst_pipe_q <= 2'b11;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    // Free-running counters, step tick and input capture.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no
        // latch can be inferred.
        rst_pipe_d = {rst_pipe_q[0], 1'b0};
        led_d      = led_i;
        tick       = (presc_q == PS_LAST);
        presc_d    = tick ? '0 : presc_q + PS_W'(1);
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    end

    // Per-channel fade FSM; only a tick can move state or brightness.
    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
            state_d[i]  = state_q[i];
            bright_d[i] = bright_q[i];
            if (tick) begin
                unique case (state_q[i])
                    ST_OFF: begin
                        if (led_q[i] && (max_level != '0)) begin
                            state_d[i] = ST_RISE;
                        end
                    end
                    ST_RISE: begin
                        // A reversal only changes direction; brightness holds.
                        if (!led_q[i]) begin
                            state_d[i] = ST_FALL;
                        end else if (max_level == '0) begin
                            state_d[i]  = ST_OFF;
                            bright_d[i] = '0;
                        end else if (bright_q[i] >= max_level - PWM_BITS'(1)) begin
                            // Reaching the ceiling, or the ceiling dropped
                            // below us: clamp and settle.
                            state_d[i]  = ST_ON;
                            bright_d[i] = max_level;
                        end else begin
                            bright_d[i] = bright_q[i] + PWM_BITS'(1);
                        end
                    end
                    ST_ON: begin
                        if (!led_q[i]) begin
                            state_d[i] = ST_FALL;
                        end else if (max_level == '0) begin
                            state_d[i]  = ST_OFF;
                            bright_d[i] = '0;
                        end else begin
                            bright_d[i] = max_level;
                        end
                    end
                    ST_FALL: begin
                        if (led_q[i]) begin
                            state_d[i] = ST_RISE;
                        end else if (bright_q[i] <= PWM_BITS'(1)) begin
                            state_d[i]  = ST_OFF;
                            bright_d[i] = '0;
                        end else begin
                            bright_d[i] = bright_q[i] - PWM_BITS'(1);
                        end
                    end
                    default: begin
                        state_d[i]  = ST_OFF;
                        bright_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Duty shadow, PWM compare and busy flag.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < N_LED; i++) begin
            // Duty only follows brightness on the last count of a frame, so a
            // frame never sees its compare value change part-way through.
            duty_d[i]  = (pwm_cnt_q == CNT_LAST) ? bright_q[i] : duty_q[i];
            led_o_d[i] = (pwm_cnt_q < duty_q[i]);
            // Built from next state so busy lines up with the state register.
            if ((state_d[i] == ST_RISE) || (state_d[i] == ST_FALL)) begin
                busy_d = 1'b1;
            end
        end
    end

    // All fader, PWM and output registers; async reset clears led_o at once.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            led_q     <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            // NOTE: the per-channel arrays are ordinary flops, not RAM, so
            // they are cleared by reset like every other register.
            bright_q  <= '0;
            duty_q    <= '0;
            led_o_q   <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                state_q[i] <= ST_OFF;
            end
        end else begin
            led_q     <= led_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            bright_q  <= bright_d;
            duty_q    <= duty_d;
            led_o_q   <= led_o_d;
            busy_q    <= busy_d;
            for (int i = 0; i < N_LED; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign led_o = led_o_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed stimulus with scoreboarded busy-ramp lengths and
// per-frame PWM duty measurements for led_fade_pwm (PRESCALE=4, 4-bit PWM).
module tb_led_fade_pwm;

    localparam int N_LED    = 4;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_LED-1:0]    led_i;
    logic [PWM_BITS-1:0] max_level;
    logic [N_LED-1:0]    led_o;
    logic                busy;

    led_fade_pwm #(
        .N_LED   (N_LED),
        .PWM_BITS(PWM_BITS),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led_i    (led_i),
        .max_level(max_level),
        .led_o    (led_o),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected busy-high lengths (cycles) and expected per-frame duty counts.
    int exp_busy_q[$];
    int exp_duty_q[$];

    bit mon_en       = 1'b0;
    bit mono_en      = 1'b0;
    bit watch_others = 1'b0;
    bit others_seen  = 1'b0;
    int mon_ch       = 0;
    int mono_prev    = 15;
    int mono_frames  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // One completed PWM frame on the monitored channel.
    task automatic emit(input int len, input int hi, input int falls);
        if (mon_en && exp_duty_q.size() > 0) begin
            check("frame_len", len, 16);
            check("frame_edges", falls, 1);
            check("frame_duty", hi, exp_duty_q.pop_front());
        end
        if (mono_en) begin
            check("fall_frame_len", len, 16);
            check_range("fall_frame_duty", hi, mono_prev - 4, mono_prev);
            mono_prev = hi;
            mono_frames++;
        end
    endtask

    // Busy monitor: every completed busy pulse is checked against the queue.
    initial begin
        int  blen;
        bit  bprev;
        blen  = 0;
        bprev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                blen  = 0;
                bprev = 1'b0;
            end else begin
                if (busy) blen++;
                if (bprev && !busy) begin
                    if (exp_busy_q.size() == 0) check("busy_unexpected", blen, -1);
                    else check("busy_len", blen, exp_busy_q.pop_front());
                    blen = 0;
                end
                bprev = busy;
            end
        end
    end

    // Frame monitor: a frame runs from one rising edge of led_o[mon_ch] to the next.
    initial begin
        int f_len, f_hi, f_fall, last_ch;
        bit f_in, prev_o, cur;
        f_len = 0; f_hi = 0; f_fall = 0; last_ch = 0;
        f_in = 1'b0; prev_o = 1'b0;
        forever begin
            @(negedge clk);
            cur = led_o[mon_ch];
            if (rst || mon_ch != last_ch) begin
                f_in    = 1'b0;
                prev_o  = rst ? 1'b0 : cur;
                last_ch = mon_ch;
            end else begin
                if (cur && !prev_o) begin
                    if (f_in) emit(f_len, f_hi, f_fall);
                    f_in = 1'b1; f_len = 1; f_hi = 1; f_fall = 0;
                end else if (f_in) begin
                    if (f_len == 16) begin
                        emit(16, f_hi, f_fall);
                        f_in = 1'b0;
                    end else begin
                        f_len++;
                        if (cur) f_hi++;
                        if (!cur && prev_o) f_fall++;
                    end
                end
                prev_o = cur;
            end
        end
    end

    // Idle-channel watcher used during the ch0 ramp.
    initial begin
        forever begin
            @(negedge clk);
            if (watch_others && !rst && (led_o[3:1] != 3'b000)) others_seen = 1'b1;
        end
    end

    task automatic wait_busy_rise(output int k);
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!busy) check("busy_rise_timeout", int'(busy), 1);
    endtask

    task automatic wait_busy_done(input int budget);
        int n;
        n = 0;
        while (exp_busy_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_busy_q.size() != 0) begin
            check("busy_done_timeout", exp_busy_q.size(), 0);
            exp_busy_q.delete();
        end
    endtask

    task automatic wait_duty_done(input int budget);
        int n;
        n = 0;
        while (exp_duty_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_duty_q.size() != 0) begin
            check("duty_done_timeout", exp_duty_q.size(), 0);
            exp_duty_q.delete();
        end
    endtask

    task automatic count_high(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (led_o[ch]) cnt++;
        end
    endtask

    initial begin
        int k;
        int cnt;
        rst       = 1'b1;
        led_i     = '0;
        max_level = 4'd15;
        repeat (4) @(negedge clk);
        check("reset_led_o", int'(led_o), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Ramp up ch0 to 15: 15 steps after the OFF->RISE tick = 60 cycles busy.
        others_seen  = 1'b0;
        watch_others = 1'b1;
        exp_busy_q.push_back(60);
        led_i = 4'b0001;
        wait_busy_rise(k);
        check_range("busy_rise_latency", k, 1, 5);
        wait_busy_done(200);
        repeat (40) @(negedge clk);
        mon_ch = 0;
        exp_duty_q.push_back(15);
        exp_duty_q.push_back(15);
        mon_en = 1'b1;
        wait_duty_done(100);
        mon_en       = 1'b0;
        watch_others = 1'b0;
        check("others_stay_dark", int'(others_seen), 0);

        // Ramp down from 15: FALL tick then 15 decrements = 60 cycles busy.
        mono_prev   = 15;
        mono_frames = 0;
        mono_en     = 1'b1;
        exp_busy_q.push_back(60);
        led_i = 4'b0000;
        wait_busy_done(200);
        repeat (40) @(negedge clk);
        mono_en = 1'b0;
        check_range("fall_frames_seen", mono_frames, 3, 8);
        check_range("fall_last_duty", mono_prev, 1, 4);
        count_high(0, 32, cnt);
        check("fall_end_dark", cnt, 0);

        // Reversal: up to 6 (ticks 1..6), FALL at tick 7 holding 6, down to 3
        // by tick 10, RISE at tick 11 holding 3, then 4..15 by tick 23 = 92 cycles.
        exp_busy_q.push_back(92);
        led_i = 4'b0001;
        wait_busy_rise(k);
        repeat (24) @(posedge clk);
        #1 led_i = 4'b0000;
        repeat (16) @(posedge clk);
        #1 led_i = 4'b0001;
        wait_busy_done(200);

        // Bring ch0 back to OFF.
        exp_busy_q.push_back(60);
        led_i = 4'b0000;
        wait_busy_done(200);

        // Ceiling on ch1: ON at 15, then max_level 5 -> 5/16, then 0 -> OFF.
        mon_ch = 1;
        exp_busy_q.push_back(60);
        led_i = 4'b0010;
        wait_busy_done(200);
        repeat (8) @(negedge clk);
        max_level = 4'd5;
        repeat (48) @(negedge clk);
        exp_duty_q.push_back(5);
        exp_duty_q.push_back(5);
        mon_en = 1'b1;
        wait_duty_done(100);
        mon_en    = 1'b0;
        max_level = 4'd0;
        repeat (48) @(negedge clk);
        count_high(1, 32, cnt);
        check("ceiling_zero_dark", cnt, 0);
        check("ceiling_zero_busy", int'(busy), 0);

        // Asynchronous reset in the middle of a ch2 ramp.
        led_i     = 4'b0000;
        max_level = 4'd15;
        repeat (8) @(negedge clk);
        led_i = 4'b0100;
        k = 0;
        while (!led_o[2] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reset_pre_led", int'(led_o[2]), 1);
        check("reset_pre_busy", int'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_led_o", int'(led_o), 0);
        check("async_reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        led_i = 4'b0000;
        rst   = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (led_o != '0 || busy) cnt++;
        end
        check("post_reset_quiet", cnt, 0);

        check("busy_queue_drained", exp_busy_q.size(), 0);
        check("duty_queue_drained", exp_duty_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
